memory_game_ctrl: RTL and testbench
===================================

// Module: memory_game_ctrl
// PURPOSE
// Parametrised round controller for the memory (repeat-the-sequence) game.
// It generates a random sequence that grows by one step each round and plays
// it back to the display. It then checks the player's button presses step by
// step, tracks score and mistakes, and ends the game on MAX_MISTAKES or a full
// MAX_LEN win. It sits between the button debouncers and the LED/7-seg drivers.
// PARAMETERS
// CHANNELS      4          number of buttons/LEDs; power of two, >=2
// MAX_LEN       16         max sequence length (storage depth)
// MAX_MISTAKES  3          mistakes that end the game, >=1
// SCORE_W       8          score width
// SHOW_CYCLES   25000000   cycles each step is lit, and cycles of gap after it
// SEED          16'hACE1   LFSR reset value, must be nonzero
// TIMEOUT_CYCLES 250000000 input timeout (only with MEMGAME_TIMEOUT_EN)
// Derived: CH_W=$clog2(CHANNELS), LEN_W=$clog2(MAX_LEN+1), MISS_W=$clog2(MAX_MISTAKES+1)
// PORTS
// clk        in   1        system clock
// reset_n    in   1        synchronous, active-low reset
// start      in   1        1-cycle pulse; starts a game from IDLE or DONE
// btn_valid  in   1        1-cycle pulse; player pressed btn_id
// btn_id     in   CH_W     pressed button index
// show_valid out  1        high while a sequence step is lit
// show_id    out  CH_W     step being lit; 0 when show_valid low
// await_in   out  1        high in INPUT state
// score      out  SCORE_W  accumulated score
// mistakes   out  MISS_W   mistakes this game
// round_len  out  LEN_W    current sequence length
// game_over  out  1        high in DONE
// win        out  1        high in DONE if MAX_LEN completed
// BEHAVIOUR
// - Reset (reset_n=0 at a clk edge): state IDLE. All outputs 0. LFSR=SEED.
//   Reset mid-round aborts immediately and clears the sequence.
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs every cycle from reset.
//   GEN appends lfsr[CH_W-1:0].
// - States: IDLE, GEN, SHOW, INPUT, SCORE, DONE.
//   IDLE -start-> GEN, which clears score and mistakes and sets round_len=0.
//   GEN: seq[round_len] <= lfsr bits; round_len++ ; step idx=0; -> SHOW (1 cycle).
//   SHOW: for idx 0..round_len-1, show_valid=1 for SHOW_CYCLES, then 0 for
//     SHOW_CYCLES. After the last gap: idx=0, -> INPUT.
//   INPUT: on btn_valid, compare btn_id with seq[idx].
//     Mismatch: fail -> SCORE.
//     Match with idx==round_len-1: pass -> SCORE.
//     Match otherwise: idx++.
//   SCORE (1 cycle):
//     Pass: score += round_len, saturating at 2^SCORE_W-1.
//       If round_len==MAX_LEN -> DONE with win=1; else -> GEN.
//     Fail: mistakes++.
//       If mistakes reaches MAX_MISTAKES -> DONE with win=0; else -> SHOW
//       (replays the same sequence, no append, idx=0).
//   DONE: hold all outputs. start -> GEN, clearing score, mistakes and win.
// - btn_valid outside INPUT is ignored. start outside IDLE/DONE is ignored.
// - Latency: start at edge t -> GEN at t+1, show_valid first high at t+2.
//   The deciding btn_valid at t -> SCORE at t+1, counters updated at t+2.
// CONFIGURATION
// MEMGAME_TIMEOUT_EN defined:
//   - A counter runs in INPUT and resets on every btn_valid.
//   - Reaching TIMEOUT_CYCLES-1 with no press is treated as a fail -> SCORE.
//   - btn_valid in that same cycle wins over the timeout.
// MEMGAME_TIMEOUT_EN undefined:
//   - No counter is built and TIMEOUT_CYCLES is unused.
//   - INPUT waits indefinitely.
// TESTING (CHANNELS=4, SHOW_CYCLES=2, MAX_MISTAKES=3, MAX_LEN=4)
// 1) reset_n=0 for 2 cycles, then start -> GEN at next edge, round_len=1;
//    show_valid high 2 cycles, low 2 cycles; then await_in=1.
// 2) Replay the correct id for rounds 1..4 -> score=1+2+3+4=10;
//    game_over=1, win=1, round_len=4.
// 3) Round 2: wrong id at step 0 -> mistakes=1, score unchanged;
//    same 2-step sequence replayed (show_id matches the first showing).
// 4) Three wrong presses -> mistakes=3, game_over=1, win=0;
//    further btn_valid leaves every output unchanged.
// 5) btn_valid during SHOW and start during INPUT -> no state change;
//    then reset_n=0 mid-INPUT -> IDLE, all outputs 0 next cycle.
// 6) MEMGAME_TIMEOUT_EN with TIMEOUT_CYCLES=10: no press for 10 cycles in INPUT
//    -> mistakes=1 and replay; a press in the 10th cycle gives no mistake.

Source files
------------

// File: rtl/memory_game_ctrl_if.sv
// Interface between the memory game controller and its surroundings.
// The master side is the button debouncers and the display drivers.
// The slave side is the round controller.
interface memory_game_ctrl_if #(
    parameter int CHANNELS     = 4,
    parameter int MAX_LEN      = 16,
    parameter int MAX_MISTAKES = 3,
    parameter int SCORE_W      = 8
);
    localparam int CH_W   = $clog2(CHANNELS);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int MISS_W = $clog2(MAX_MISTAKES + 1);

    logic              start;
    logic              btn_valid;
    logic [CH_W-1:0]   btn_id;
    logic              show_valid;
    logic [CH_W-1:0]   show_id;
    logic              await_in;
    logic [SCORE_W-1:0] score;
    logic [MISS_W-1:0] mistakes;
    logic [LEN_W-1:0]  round_len;
    logic              game_over;
    logic              win;

    modport master (
        output start, btn_valid, btn_id,
        input  show_valid, show_id, await_in, score, mistakes, round_len, game_over, win
    );

    modport slave (
        input  start, btn_valid, btn_id,
        output show_valid, show_id, await_in, score, mistakes, round_len, game_over, win
    );
endinterface

// File: rtl/memory_game_ctrl.sv
// Round controller for the repeat-the-sequence memory game.
// It grows a random sequence by one step per round, plays it back, checks
// the player's presses, and keeps score and mistakes.
// Optional macro MEMGAME_TIMEOUT_EN: an idle INPUT lasting TIMEOUT_CYCLES
// counts as a wrong press.
module memory_game_ctrl #(
    parameter int          CHANNELS       = 4,
    parameter int          MAX_LEN        = 16,
    parameter int          MAX_MISTAKES   = 3,
    parameter int          SCORE_W        = 8,
    parameter int          SHOW_CYCLES    = 25000000,
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter int          TIMEOUT_CYCLES = 250000000
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    memory_game_ctrl_if.slave   bus
);
    localparam int CH_W   = $clog2(CHANNELS);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int MISS_W = $clog2(MAX_MISTAKES + 1);
    localparam int IDX_W  = $clog2(MAX_LEN);
    localparam int TM_W   = $clog2(2 * SHOW_CYCLES);
    localparam int SUM_W  = ((SCORE_W > LEN_W) ? SCORE_W : LEN_W) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GEN   = 3'd1;
    localparam logic [2:0] S_SHOW  = 3'd2;
    localparam logic [2:0] S_INPUT = 3'd3;
    localparam logic [2:0] S_SCORE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Reject parameter sets the datapath cannot represent.
    if (SEED == 16'h0 || CHANNELS < 2 || (CHANNELS & (CHANNELS - 1)) != 0 ||
        MAX_LEN < 2 || MAX_MISTAKES < 1 || SHOW_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("memory_game_ctrl: illegal parameter set");
    end

    logic [2:0]         state_q, state_d;
    logic [15:0]        lfsr_q;
    logic [CH_W-1:0]    seq_q [MAX_LEN];
    logic               seq_we;
    logic [LEN_W-1:0]   round_len_q, round_len_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TM_W-1:0]    timer_q, timer_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [MISS_W-1:0]  mistakes_q, mistakes_d;
    logic               win_q, win_d;
    logic               pass_q, pass_d;

    logic               idx_last;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic               show_valid;

`ifdef MEMGAME_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0]    to_q, to_d;
`endif

    // idx points at the step being shown or awaited; last step is round_len-1.
    assign idx_last  = (LEN_W'(idx_q) == round_len_q - LEN_W'(1));
    assign score_sum = SUM_W'(score_q) + SUM_W'(round_len_q);
    assign score_sat = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    // Next-state and datapath updates for the round sequencer.
    always_comb begin
        state_d     = state_q;
        round_len_d = round_len_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        score_d     = score_q;
        mistakes_d  = mistakes_q;
        win_d       = win_q;
        pass_d      = pass_q;
        seq_we      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d     = S_GEN;
                    round_len_d = '0;
                    score_d     = '0;
                    mistakes_d  = '0;
                    win_d       = 1'b0;
                end
            end
            S_GEN: begin
                seq_we      = 1'b1;
                round_len_d = round_len_q + LEN_W'(1);
                idx_d       = '0;
                timer_d     = '0;
                state_d     = S_SHOW;
            end
            S_SHOW: begin
                // Each step is lit for SHOW_CYCLES then dark for SHOW_CYCLES.
                if (timer_q == TM_W'(2 * SHOW_CYCLES - 1)) begin
                    timer_d = '0;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = S_INPUT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            S_INPUT: begin
                if (bus.btn_valid) begin
                    if (bus.btn_id != seq_q[idx_q]) begin
                        pass_d  = 1'b0;
                        state_d = S_SCORE;
                    end else if (idx_last) begin
                        pass_d  = 1'b1;
                        state_d = S_SCORE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
`ifdef MEMGAME_TIMEOUT_EN
                else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    pass_d  = 1'b0;
                    state_d = S_SCORE;
                end
`endif
            end
            S_SCORE: begin
                if (pass_q) begin
                    score_d = score_sat;
                    if (round_len_q == LEN_W'(MAX_LEN)) begin
                        win_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GEN;
                    end
                end else begin
                    mistakes_d = mistakes_q + MISS_W'(1);
                    if (mistakes_d == MISS_W'(MAX_MISTAKES)) begin
                        state_d = S_DONE;
                    end else begin
                        // Replay the unchanged sequence from its first step.
                        idx_d   = '0;
                        timer_d = '0;
                        state_d = S_SHOW;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MEMGAME_TIMEOUT_EN
    // Idle counter: runs only while waiting in INPUT, cleared by any press.
    always_comb begin
        to_d = '0;
        if (state_q == S_INPUT && state_d == S_INPUT && !bus.btn_valid)
            to_d = to_q + TO_W'(1);
    end

    // Idle counter register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) to_q <= '0;
        else            to_q <= to_d;
    end
`endif

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            round_len_q <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            score_q     <= '0;
            mistakes_q  <= '0;
            win_q       <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_len_q <= round_len_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            score_q     <= score_d;
            mistakes_q  <= mistakes_d;
            win_q       <= win_d;
            pass_q      <= pass_d;
        end
    end

    // Free-running Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) lfsr_q <= SEED;
        else            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // Sequence store: GEN appends the low LFSR bits; reset wipes it.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < MAX_LEN; i++) seq_q[i] <= '0;
        end else if (seq_we) begin
            seq_q[round_len_q[IDX_W-1:0]] <= lfsr_q[CH_W-1:0];
        end
    end

    assign show_valid     = (state_q == S_SHOW) && (timer_q < TM_W'(SHOW_CYCLES));
    assign bus.show_valid = show_valid;
    assign bus.show_id    = show_valid ? seq_q[idx_q] : '0;
    assign bus.await_in   = (state_q == S_INPUT);
    assign bus.score      = score_q;
    assign bus.mistakes   = mistakes_q;
    assign bus.round_len  = round_len_q;
    assign bus.game_over  = (state_q == S_DONE);
    assign bus.win        = win_q;
endmodule

// File: tb/tb_memory_game_ctrl.sv
// Self-checking bench for memory_game_ctrl: directed game scenarios plus a
// randomized phase, all checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_memory_game_ctrl;
    localparam int CH = 4, ML = 4, MM = 3, SW = 8, SC = 2, TO = 10, CW = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, bv = 1'b0;
    logic [CW-1:0] bid = '0;
    always #5 clk = ~clk;

    memory_game_ctrl_if #(.CHANNELS(CH), .MAX_LEN(ML), .MAX_MISTAKES(MM), .SCORE_W(SW)) bus ();
    memory_game_ctrl_if #(.CHANNELS(CH), .MAX_LEN(ML), .MAX_MISTAKES(MM), .SCORE_W(3))  bus3 ();
    assign bus.start  = start;  assign bus.btn_valid  = bv;  assign bus.btn_id  = bid;
    assign bus3.start = start;  assign bus3.btn_valid = bv;  assign bus3.btn_id = bid;

    memory_game_ctrl #(.CHANNELS(CH), .MAX_LEN(ML), .MAX_MISTAKES(MM), .SCORE_W(SW),
        .SHOW_CYCLES(SC), .SEED(SEED), .TIMEOUT_CYCLES(TO))
        dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus));
    // Narrow-score copy exercises saturation on the same stimulus.
    memory_game_ctrl #(.CHANNELS(CH), .MAX_LEN(ML), .MAX_MISTAKES(MM), .SCORE_W(3),
        .SHOW_CYCLES(SC), .SEED(SEED), .TIMEOUT_CYCLES(TO))
        dut3 (.clk_i(clk), .reset_n_i(rst_n), .bus(bus3));

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_GEN, M_SHOW, M_INPUT, M_SCORE, M_DONE} mode_t;
    mode_t    mode = M_IDLE;
    bit [15:0] lf;
    int       seqm[$];
    int       score_m, mis_m, step_m, show_t, in_t;
    bit       win_m, pass_m, model_ok = 0;

    function automatic bit [15:0] lfsr_next(input bit [15:0] v);
        bit [15:0] b;
        b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h1;
        return (v >> 1) | (b << 15);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mode = M_IDLE; lf = SEED; seqm.delete();
            score_m = 0; mis_m = 0; win_m = 0; step_m = 0; show_t = 0; in_t = 0; pass_m = 0;
            model_ok = 1;
        end else if (model_ok) begin
            case (mode)
                M_IDLE, M_DONE: if (start) begin
                    score_m = 0; mis_m = 0; win_m = 0; seqm.delete(); mode = M_GEN;
                end
                M_GEN: begin seqm.push_back(int'(lf) % CH); show_t = 0; mode = M_SHOW; end
                M_SHOW: begin
                    show_t++;
                    if (show_t == 2 * SC * seqm.size()) begin mode = M_INPUT; step_m = 0; in_t = 0; end
                end
                M_INPUT: begin
                    if (bv) begin
                        in_t = 0;
                        if (int'(bid) != seqm[step_m]) begin pass_m = 0; mode = M_SCORE; end
                        else if (step_m == seqm.size() - 1) begin pass_m = 1; mode = M_SCORE; end
                        else step_m++;
                    end
`ifdef MEMGAME_TIMEOUT_EN
                    else if (in_t == TO - 1) begin pass_m = 0; mode = M_SCORE; end
                    else in_t++;
`endif
                end
                M_SCORE: begin
                    if (pass_m) begin
                        score_m += seqm.size();
                        if (seqm.size() == ML) begin win_m = 1; mode = M_DONE; end
                        else mode = M_GEN;
                    end else begin
                        mis_m++;
                        if (mis_m == MM) mode = M_DONE;
                        else begin show_t = 0; mode = M_SHOW; end
                    end
                end
                default: mode = M_IDLE;
            endcase
            lf = lfsr_next(lf);
        end
    end

    function automatic int exp_sv();
        return (mode == M_SHOW && (show_t % (2 * SC)) < SC) ? 1 : 0;
    endfunction
    function automatic int exp_id();
        return (exp_sv() != 0) ? seqm[show_t / (2 * SC)] : 0;
    endfunction
    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("show_valid", int'(bus.show_valid), exp_sv());
            chk("show_id",    int'(bus.show_id),    exp_id());
            chk("await_in",   int'(bus.await_in),   int'(mode == M_INPUT));
            chk("score",      int'(bus.score),      sat(score_m, 255));
            chk("score_w3",   int'(bus3.score),     sat(score_m, 7));
            chk("mistakes",   int'(bus.mistakes),   mis_m);
            chk("round_len",  int'(bus.round_len),  seqm.size());
            chk("game_over",  int'(bus.game_over),  int'(mode == M_DONE));
            chk("win",        int'(bus.win),        int'(win_m));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic press(input int id);
        bid = CW'(id); bv = 1'b1; cyc(1); bv = 1'b0; bid = '0;
    endtask
    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask
    int lit_ids[$];
    task automatic wait_input(input int budget);
        int n;
        n = 0;
        lit_ids.delete();
        while (!bus.await_in && n < budget) begin
            if (bus.show_valid) lit_ids.push_back(int'(bus.show_id));
            cyc(1); n++;
        end
        chk("wait_await_in", int'(bus.await_in), 1);
    endtask
    function automatic int wrong_id(input int c);
        return (c + 1 + int'($urandom_range(0, CH - 2))) % CH;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the model's LFSR against hand-computed steps from the seed.
        chk("lfsr_pin1", int'(lfsr_next(16'hACE1)), 32'h5670);
        chk("lfsr_pin2", int'(lfsr_next(16'h5670)), 32'hAB38);

        // Reset for two cycles, then one idle cycle.
        cyc(2); rst_n = 1'b1;
        chk("rst_round_len", int'(bus.round_len), 0);
        chk("rst_game_over", int'(bus.game_over), 0);
        cyc(1);

        // Start: GEN next cycle, then 2 lit, 2 dark, then INPUT.
        pulse_start();
        chk("t1_gen_sv",  int'(bus.show_valid), 0);
        chk("t1_gen_len", int'(bus.round_len), 0);
        cyc(1); chk("t1_sv0", int'(bus.show_valid), 1); chk("t1_len", int'(bus.round_len), 1);
        cyc(1); chk("t1_sv1", int'(bus.show_valid), 1);
        cyc(1); chk("t1_sv2", int'(bus.show_valid), 0);
        cyc(1); chk("t1_sv3", int'(bus.show_valid), 0);
        cyc(1); chk("t1_await", int'(bus.await_in), 1);

        // Win a full game: score 1+2+3+4.
        for (int r = 1; r <= ML; r++) begin
            wait_input(200);
            for (int s = 0; s < r; s++) begin
                cyc($urandom_range(0, 2));
                press(seqm[step_m]);
            end
        end
        cyc(2);
        chk("t2_score", int'(bus.score), 10);
        chk("t2_score_sat", int'(bus3.score), 7);
        chk("t2_win", int'(bus.win), 1);
        chk("t2_over", int'(bus.game_over), 1);
        chk("t2_len", int'(bus.round_len), 4);

        // Mistakes: replay of the same sequence, then game over.
        pulse_start();
        wait_input(200); press(seqm[0]);
        wait_input(200); press(wrong_id(seqm[0]));
        cyc(1);
        chk("t3_mis", int'(bus.mistakes), 1);
        chk("t3_score", int'(bus.score), 1);
        wait_input(200);
        chk("t3_replay_lit", lit_ids.size(), 2 * SC);
        for (int i = 0; i < lit_ids.size(); i++) chk("t3_replay_id", lit_ids[i], seqm[i / SC]);
        chk("t3_len", int'(bus.round_len), 2);
        press(seqm[0]); press(wrong_id(seqm[1]));
        wait_input(200); press(wrong_id(seqm[0]));
        cyc(1);
        chk("t4_mis", int'(bus.mistakes), 3);
        chk("t4_over", int'(bus.game_over), 1);
        chk("t4_win", int'(bus.win), 0);
        for (int i = 0; i < 4; i++) begin cyc(1); press($urandom_range(0, CH - 1)); end
        chk("t4_hold_mis", int'(bus.mistakes), 3);
        chk("t4_hold_score", int'(bus.score), 1);
        chk("t4_hold_len", int'(bus.round_len), 2);

        // Ignored inputs, then reset mid-INPUT.
        pulse_start();
        wait_input(200); press(seqm[0]);
        cyc(3); press($urandom_range(0, CH - 1));   // lands in SHOW
        wait_input(200);
        pulse_start();
        chk("t5_still_input", int'(bus.await_in), 1);
        chk("t5_len", int'(bus.round_len), 2);
        rst_n = 1'b0; cyc(1);
        chk("t5_rst_sv",    int'(bus.show_valid), 0);
        chk("t5_rst_id",    int'(bus.show_id), 0);
        chk("t5_rst_await", int'(bus.await_in), 0);
        chk("t5_rst_score", int'(bus.score), 0);
        chk("t5_rst_mis",   int'(bus.mistakes), 0);
        chk("t5_rst_len",   int'(bus.round_len), 0);
        chk("t5_rst_over",  int'(bus.game_over), 0);
        chk("t5_rst_win",   int'(bus.win), 0);
        rst_n = 1'b1; cyc(1);

`ifdef MEMGAME_TIMEOUT_EN
        // Idle INPUT times out; a press in the last cycle beats the timeout.
        pulse_start();
        wait_input(200);
        cyc(TO + 1);
        chk("t6_timeout_mis", int'(bus.mistakes), 1);
        wait_input(200);
        cyc(TO - 1);
        press(seqm[0]);
        cyc(1);
        chk("t6_edge_mis", int'(bus.mistakes), 1);
        chk("t6_edge_score", int'(bus.score), 1);
`endif

        // Randomized play with occasional resets and stray starts.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            start = ($urandom_range(0, 39) == 0);
            bv    = ($urandom_range(0, 2) == 0);
            if (mode == M_INPUT && seqm.size() > 0 && $urandom_range(0, 3) != 0)
                bid = CW'(seqm[step_m]);
            else
                bid = CW'($urandom_range(0, CH - 1));
            cyc(1);
        end
        rst_n = 1'b1; start = 1'b0; bv = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
